// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and the set-2 scan-code to ASCII lookup
// used by the PS/2 ASCII decoder.
package ps2_pkg;

   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CAPS   = 8'h58;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_BS = 8'h08;
   localparam logic [7:0] ASCII_SP = 8'h20;

   typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

   // Returns {hit, ascii}; letters are folded to uppercase when upper is set.
   function automatic logic [8:0] sc2ascii(input logic [7:0] code, input logic upper);
      logic [7:0] ch;
      logic       hit;
      hit = 1'b1;
      ch  = 8'h00;
      case (code)
         8'h16: ch = 8'h31;
         8'h1E: ch = 8'h32;
         8'h26: ch = 8'h33;
         8'h25: ch = 8'h34;
         8'h2E: ch = 8'h35;
         8'h36: ch = 8'h36;
         8'h3D: ch = 8'h37;
         8'h3E: ch = 8'h38;
         8'h46: ch = 8'h39;
         8'h45: ch = 8'h30;
         8'h1C: ch = 8'h61;
         8'h32: ch = 8'h62;
         8'h21: ch = 8'h63;
         8'h23: ch = 8'h64;
         8'h24: ch = 8'h65;
         8'h2B: ch = 8'h66;
         8'h34: ch = 8'h67;
         8'h33: ch = 8'h68;
         8'h43: ch = 8'h69;
         8'h3B: ch = 8'h6A;
         8'h42: ch = 8'h6B;
         8'h4B: ch = 8'h6C;
         8'h3A: ch = 8'h6D;
         8'h31: ch = 8'h6E;
         8'h44: ch = 8'h6F;
         8'h4D: ch = 8'h70;
         8'h15: ch = 8'h71;
         8'h2D: ch = 8'h72;
         8'h1B: ch = 8'h73;
         8'h2C: ch = 8'h74;
         8'h3C: ch = 8'h75;
         8'h2A: ch = 8'h76;
         8'h1D: ch = 8'h77;
         8'h22: ch = 8'h78;
         8'h35: ch = 8'h79;
         8'h1A: ch = 8'h7A;
         8'h29: ch = ASCII_SP;
         8'h5A: ch = ASCII_CR;
         8'h66: ch = ASCII_BS;
         default: hit = 1'b0;
      endcase
      if (upper && ch >= 8'h61 && ch <= 8'h7A) ch = ch - 8'h20;
      return {hit, ch};
   endfunction

endpackage

// File: rtl/ps2_ascii_fifo.sv
// Show-ahead synchronous FIFO for decoded ASCII bytes, with a sticky
// overflow flag for pushes dropped while full.
module ps2_ascii_fifo #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       rd_en,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full,
   output logic       overflow
);

   localparam int CW = AW + 1;
   localparam logic [AW:0] FULL_COUNT = CW'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          do_wr, do_rd;

   // Handshake: wr_en is a one-cycle push, accepted unless full with no pop in
   // the same cycle; rd_en pops the head and is ignored while empty.
   assign empty = (count == '0);
   assign full  = (count == FULL_COUNT);
   assign do_rd = rd_en && !empty;
   assign do_wr = wr_en && (!full || do_rd);
   assign dout  = empty ? 8'h00 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         if (do_wr && !do_rd)      count <= count + CW'(1);
         else if (do_rd && !do_wr) count <= count - CW'(1);
         if (wr_en && !do_wr) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 byte stream to ASCII: tracks F0/E0 prefixes, Shift and Caps Lock,
// queues make events of mapped keys. Optional macro: PS2_TYPEMATIC_FILTER_EN.
module ps2_ascii_decoder
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] scan_code,
   input  logic       scan_valid,
   input  logic       rd_en,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full,
   output logic       overflow,
   output logic       shift_o,
   output logic       caps_o
);

   localparam int FIFO_AW = $clog2(FIFO_DEPTH);

   state_t     state, state_nxt;
   logic       lshift, lshift_nxt;
   logic       rshift, rshift_nxt;
   logic       caps, caps_nxt;
   logic       wr_q, wr_nxt;
   logic [7:0] data_q, data_nxt;
   logic [8:0] lookup;
   logic       repeat_make;

`ifdef PS2_TYPEMATIC_FILTER_EN
   logic [7:0] last_make, last_nxt;
   assign repeat_make = (scan_code == last_make);
`else
   assign repeat_make = 1'b0;
`endif

   assign lookup  = sc2ascii(scan_code, (lshift | rshift) ^ caps);
   assign shift_o = lshift | rshift;
   assign caps_o  = caps;

   always_comb begin
      state_nxt  = state;
      lshift_nxt = lshift;
      rshift_nxt = rshift;
      caps_nxt   = caps;
      wr_nxt     = 1'b0;
      data_nxt   = data_q;
`ifdef PS2_TYPEMATIC_FILTER_EN
      last_nxt   = last_make;
`endif
      if (scan_valid) begin
         case (state)
            IDLE: begin
               if (scan_code == SC_BREAK) state_nxt = BRK;
               else if (scan_code == SC_EXT) state_nxt = EXT;
               else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                  last_nxt = scan_code;
`endif
                  if (!repeat_make) begin
                     if (scan_code == SC_LSHIFT)      lshift_nxt = 1'b1;
                     else if (scan_code == SC_RSHIFT) rshift_nxt = 1'b1;
                     else if (scan_code == SC_CAPS)   caps_nxt   = ~caps;
                     else if (lookup[8]) begin
                        wr_nxt   = 1'b1;
                        data_nxt = lookup[7:0];
                     end
                  end
               end
            end
            BRK: begin
               state_nxt = IDLE;
               if (scan_code == SC_LSHIFT) lshift_nxt = 1'b0;
               if (scan_code == SC_RSHIFT) rshift_nxt = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
               if (scan_code == last_make) last_nxt = 8'h00;
`endif
            end
            // Extended keys are unmapped: their make and break bytes are swallowed.
            EXT:     state_nxt = (scan_code == SC_BREAK) ? EXT_BRK : IDLE;
            EXT_BRK: state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         lshift <= 1'b0;
         rshift <= 1'b0;
         caps   <= 1'b0;
         wr_q   <= 1'b0;
         data_q <= 8'h00;
`ifdef PS2_TYPEMATIC_FILTER_EN
         last_make <= 8'h00;
`endif
      end else begin
         state  <= state_nxt;
         lshift <= lshift_nxt;
         rshift <= rshift_nxt;
         caps   <= caps_nxt;
         wr_q   <= wr_nxt;
         data_q <= data_nxt;
`ifdef PS2_TYPEMATIC_FILTER_EN
         last_make <= last_nxt;
`endif
      end
   end

   ps2_ascii_fifo #(
      .DEPTH (FIFO_DEPTH),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_q),
      .wr_data  (data_q),
      .rd_en    (rd_en),
      .dout     (dout),
      .empty    (empty),
      .full     (full),
      .overflow (overflow)
   );

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Directed and randomized bench for ps2_ascii_decoder against a keyboard-level
// reference model (prefix flags, key-state booleans and an ASCII queue).
module tb_ps2_ascii_decoder;
   import ps2_pkg::*;

   localparam int DEPTH = 4;
`ifdef PS2_TYPEMATIC_FILTER_EN
   localparam bit FILTER = 1'b1;
`else
   localparam bit FILTER = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] scan_code = 8'h00;
   logic       scan_valid = 1'b0;
   logic       rd_en = 1'b0;
   logic [7:0] dout;
   logic       empty, full, overflow, shift_o, caps_o;

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [7:0] exp_q[$];
   logic [7:0] amap[logic [7:0]];
   bit         m_brk, m_ext, m_ext_brk, m_ls, m_rs, m_caps, m_ovf;
   logic [7:0] m_last;

   ps2_ascii_decoder #(.FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .scan_code  (scan_code),
      .scan_valid (scan_valid),
      .rd_en      (rd_en),
      .dout       (dout),
      .empty      (empty),
      .full       (full),
      .overflow   (overflow),
      .shift_o    (shift_o),
      .caps_o     (caps_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_brk = 0; m_ext = 0; m_ext_brk = 0;
      m_ls = 0; m_rs = 0; m_caps = 0; m_ovf = 0;
      m_last = 8'h00;
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [7:0] ch;
      bit         rep;
      if (m_ext_brk) m_ext_brk = 0;
      else if (m_ext) begin
         m_ext = 0;
         if (b == 8'hF0) m_ext_brk = 1;
      end else if (m_brk) begin
         m_brk = 0;
         if (b == 8'h12) m_ls = 0;
         if (b == 8'h59) m_rs = 0;
         if (FILTER && b == m_last) m_last = 8'h00;
      end else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE0) m_ext = 1;
      else begin
         rep = FILTER && (b == m_last);
         if (FILTER) m_last = b;
         if (!rep) begin
            if (b == 8'h12) m_ls = 1;
            else if (b == 8'h59) m_rs = 1;
            else if (b == 8'h58) m_caps = !m_caps;
            else if (amap.exists(b)) begin
               ch = amap[b];
               if (ch >= 8'h61 && ch <= 8'h7A && ((m_ls || m_rs) != m_caps)) ch = ch - 8'd32;
               if (exp_q.size() < DEPTH) exp_q.push_back(ch);
               else m_ovf = 1;
            end
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; scan_valid = 1'b0; rd_en = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic send1(input logic [7:0] b);
      @(negedge clk);
      scan_code = b; scan_valid = 1'b1;
      model_byte(b);
      @(negedge clk);
      scan_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_status(input string tag);
      chk({tag, "_empty"}, 8'(empty), 8'(exp_q.size() == 0));
      chk({tag, "_full"}, 8'(full), 8'(exp_q.size() == DEPTH));
      chk({tag, "_ovf"}, 8'(overflow), 8'(m_ovf));
      chk({tag, "_shift"}, 8'(shift_o), 8'(m_ls || m_rs));
      chk({tag, "_caps"}, 8'(caps_o), 8'(m_caps));
   endtask

   task automatic drain(input string tag);
      while (exp_q.size() > 0) begin
         chk({tag, "_nonempty"}, 8'(empty), 8'h00);
         chk({tag, "_dout"}, dout, exp_q.pop_front());
         rd_en = 1'b1;
         @(negedge clk);
         rd_en = 1'b0;
      end
      chk({tag, "_drained"}, 8'(empty), 8'h01);
   endtask

   initial begin
      logic [7:0] letters [26];
      logic [7:0] digits [10];
      logic [7:0] pool [16];
      logic [7:0] b;
      int         n, cnt;

      letters = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                  8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                  8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
      digits  = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
      pool    = '{8'h1C, 8'h22, 8'h44, 8'h16, 8'h45, 8'h29, 8'h5A, 8'h66,
                  8'h12, 8'h59, 8'h58, 8'hF0, 8'hF0, 8'hE0, 8'h1A, 8'h4D};
      for (int i = 0; i < 26; i++) amap[letters[i]] = 8'h61 + 8'(i);
      for (int i = 0; i < 10; i++) amap[digits[i]] = (i < 9) ? 8'h31 + 8'(i) : 8'h30;
      amap[8'h29] = 8'h20;
      amap[8'h5A] = 8'h0D;
      amap[8'h66] = 8'h08;

      // reset values
      do_reset();
      @(negedge clk);
      chk("rst_empty", 8'(empty), 8'h01);
      chk("rst_full", 8'(full), 8'h00);
      chk("rst_ovf", 8'(overflow), 8'h00);
      chk("rst_shift", 8'(shift_o), 8'h00);
      chk("rst_caps", 8'(caps_o), 8'h00);
      chk("rst_dout", dout, 8'h00);
      chk("rst_state", 8'(dut.state), 8'(IDLE));

      // first-byte latency: empty until N+2
      @(negedge clk);
      scan_code = 8'h1C; scan_valid = 1'b1;
      model_byte(8'h1C);
      @(negedge clk);
      scan_valid = 1'b0;
      chk("lat_n1_empty", 8'(empty), 8'h01);
      @(negedge clk);
      chk("lat_n2_empty", 8'(empty), 8'h00);
      chk("lat_n2_dout", dout, 8'h61);
      drain("lat");

      // shift held, released
      send1(8'h12);
      chk("shift_on", 8'(shift_o), 8'h01);
      send1(8'h22);
      send1(8'hF0); send1(8'h12);
      chk("shift_off", 8'(shift_o), 8'h00);
      send1(8'h22);
      chk("shift_head", dout, 8'h58);
      check_status("shift");
      drain("shift");

      // caps lock toggling
      send1(8'h58);
      chk("caps_on", 8'(caps_o), 8'h01);
      send1(8'h44);
      send1(8'h58);
      chk("caps_off", 8'(caps_o), 8'h00);
      send1(8'h16);
      chk("caps_head", dout, 8'h4F);
      check_status("caps");
      drain("caps");

      // extended and break sequences produce nothing
      send1(8'hE0); send1(8'h75);
      send1(8'hE0); send1(8'hF0); send1(8'h75);
      send1(8'hF0); send1(8'h1C);
      send1(8'hFF);
      chk("ext_empty", 8'(empty), 8'h01);
      chk("ext_state", 8'(dut.state), 8'(IDLE));

      // read while empty is ignored
      rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
      send1(8'h1C);
      chk("rdempty_head", dout, 8'h61);
      drain("rdempty");

      // write and read in the same cycle on an empty FIFO: write lands
      @(negedge clk);
      scan_code = 8'h32; scan_valid = 1'b1;
      model_byte(8'h32);
      @(negedge clk);
      scan_valid = 1'b0; rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      chk("wr_rd_empty_head", dout, 8'h62);
      check_status("wr_rd_empty");
      drain("wr_rd_empty");

      // fill, swap at full, overflow
      send1(8'h1C); send1(8'h32); send1(8'h21); send1(8'h23);
      chk("fill_full", 8'(full), 8'h01);
      chk("fill_ovf", 8'(overflow), 8'h00);
      @(negedge clk);
      scan_code = 8'h24; scan_valid = 1'b1;
      @(negedge clk);
      scan_valid = 1'b0; rd_en = 1'b1;
      void'(exp_q.pop_front());
      model_byte(8'h24);
      @(negedge clk);
      rd_en = 1'b0;
      chk("swap_full", 8'(full), 8'h01);
      chk("swap_ovf", 8'(overflow), 8'h00);
      chk("swap_head", dout, 8'h62);
      send1(8'h2B);
      chk("ovf_set", 8'(overflow), 8'h01);
      chk("ovf_head", dout, 8'h62);
      check_status("ovf");
      drain("ovf");
      chk("ovf_sticky", 8'(overflow), 8'h01);

      // reset mid-sequence discards a pending break prefix
      send1(8'hF0);
      do_reset();
      send1(8'h1C);
      chk("midrst_ovf", 8'(overflow), 8'h00);
      chk("midrst_head", dout, 8'h61);
      drain("midrst");

      // typematic repeats
      send1(8'h1C); send1(8'h1C); send1(8'h1C);
      send1(8'hF0); send1(8'h1C);
      send1(8'h1C);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (!empty) begin
            chk("typ_dout", dout, 8'h61);
            cnt++;
            rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
         end
      end
      chk("typ_count", 8'(cnt), FILTER ? 8'd2 : 8'd4);
      exp_q.delete();

      // randomized back-to-back bursts
      do_reset();
      for (int r = 0; r < 40; r++) begin
         n = $urandom_range(1, 6);
         for (int k = 0; k < n; k++) begin
            @(negedge clk);
            b = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                             : pool[$urandom_range(0, 15)];
            if ($urandom_range(0, 3) == 0) b = letters[$urandom_range(0, 25)];
            scan_code = b; scan_valid = 1'b1;
            model_byte(b);
         end
         @(negedge clk);
         scan_valid = 1'b0;
         @(negedge clk);
         check_status("rnd");
         if ($urandom_range(0, 1) == 1) drain("rnd");
      end
      drain("rnd_final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
